// File: rtl/sram_pkg.sv
// Shared encodings for the SRAM-like bus: transfer sizes, arbiter FSM states
// and the owner encoding used by the 2:1 arbiter.
package sram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on contention the master
// that was not granted last wins. Grant is one-hot {data, inst}.
module rr_pick2
    import sram_pkg::*;
(
    input  logic       req_inst,
    input  logic       req_data,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req_inst && req_data) begin
            if (last == OWN_DATA) gnt = 2'b01;
            else                  gnt = 2'b10;
        end else if (req_inst) begin
            gnt = 2'b01;
        end else if (req_data) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter_2_1.sv
// Two-master, one-slave SRAM-like bus arbiter with one outstanding transaction,
// round-robin tie-break and a grant lock held from request until addr_ok.
module sram_arbiter_2_1
    import sram_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        slv_req,
    output logic        slv_wr,
    output logic [1:0]  slv_size,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    input  logic [31:0] slv_rdata,
    input  logic        slv_addr_ok,
    input  logic        slv_data_ok
);

    arb_state_t state;
    logic       owner;
    logic       last;
    logic [1:0] gnt;
    logic       win_vld;
    logic       winner;
    logic       sel;
    logic       active;
    logic       resp_ok;

    rr_pick2 u_pick (
        .req_inst (inst_req),
        .req_data (data_req),
        .last     (last),
        .gnt      (gnt)
    );

    assign win_vld = |gnt;
    assign winner  = gnt[1];

    // In IDLE the fresh winner is forwarded; in ADDR the locked owner is held.
    always_comb begin
        sel    = (state == ST_IDLE) ? winner : owner;
        active = resetn && (((state == ST_IDLE) && win_vld) || (state == ST_ADDR));
    end

    always_comb begin
        slv_req   = active;
        slv_wr    = 1'b0;
        slv_size  = '0;
        slv_addr  = '0;
        slv_wdata = '0;
        if (active) begin
            slv_wr    = (sel == OWN_DATA) ? data_wr    : inst_wr;
            slv_size  = (sel == OWN_DATA) ? data_size  : inst_size;
            slv_addr  = (sel == OWN_DATA) ? data_addr  : inst_addr;
            slv_wdata = (sel == OWN_DATA) ? data_wdata : inst_wdata;
        end
    end

    assign resp_ok      = resetn && (state == ST_DATA) && slv_data_ok;
    assign inst_addr_ok = active && (sel == OWN_INST) && slv_addr_ok;
    assign data_addr_ok = active && (sel == OWN_DATA) && slv_addr_ok;
    assign inst_data_ok = resp_ok && (owner == OWN_INST);
    assign data_data_ok = resp_ok && (owner == OWN_DATA);
    assign inst_rdata   = slv_rdata;
    assign data_rdata   = slv_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            owner <= OWN_INST;
            last  <= !DATA_FIRST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        owner <= winner;
                        if (slv_addr_ok) begin
                            last  <= winner;
                            state <= ST_DATA;
                        end else begin
                            state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (slv_addr_ok) begin
                        last  <= owner;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (slv_data_ok) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_2_1.sv
// Self-checking bench for sram_arbiter_2_1: directed scenarios plus randomized
// masters/slave, all compared against a transaction-level reference model.
module tb_sram_arbiter_2_1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        slv_req, slv_wr;
    logic [1:0]  slv_size;
    logic [31:0] slv_addr, slv_wdata, slv_rdata;
    logic        slv_addr_ok, slv_data_ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter_2_1 #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .slv_req(slv_req), .slv_wr(slv_wr), .slv_size(slv_size),
        .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
        .slv_addr_ok(slv_addr_ok), .slv_data_ok(slv_data_ok)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transaction is either absent, waiting for its address
    // handshake, or waiting for its response; plus who was granted last.
    int  m_phase;      // 0 none, 1 awaiting addr_ok, 2 awaiting data_ok
    bit  m_own;        // 0 inst, 1 data
    bit  m_last;
    bit  m_win_v, m_win;
    bit  e_inst_aok, e_data_aok;

    task automatic model_reset();
        m_phase = 0;
        m_own   = 1'b0;
        m_last  = 1'b0;   // opposite of DATA_FIRST=1: data wins first contention
    endtask

    task automatic settle();
        bit act, sel, e_req, e_wr, e_iok, e_dok;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        #1;
        m_win_v = inst_req || data_req;
        m_win   = (inst_req && data_req) ? !m_last : data_req;
        act = 1'b0;
        sel = 1'b0;
        if (resetn) begin
            if (m_phase == 0 && m_win_v) begin act = 1'b1; sel = m_win; end
            else if (m_phase == 1)       begin act = 1'b1; sel = m_own; end
        end
        e_req   = act;
        e_wr    = act ? (sel ? data_wr    : inst_wr)    : 1'b0;
        e_size  = act ? (sel ? data_size  : inst_size)  : 2'd0;
        e_addr  = act ? (sel ? data_addr  : inst_addr)  : 32'd0;
        e_wdata = act ? (sel ? data_wdata : inst_wdata) : 32'd0;
        e_inst_aok = act && !sel && slv_addr_ok;
        e_data_aok = act &&  sel && slv_addr_ok;
        e_iok = resetn && m_phase == 2 && !m_own && slv_data_ok;
        e_dok = resetn && m_phase == 2 &&  m_own && slv_data_ok;
        check_eq("slv_req",   slv_req,   e_req);
        check_eq("slv_wr",    slv_wr,    e_wr);
        check_eq("slv_size",  slv_size,  e_size);
        check_eq("slv_addr",  slv_addr,  e_addr);
        check_eq("slv_wdata", slv_wdata, e_wdata);
        check_eq("inst_addr_ok", inst_addr_ok, e_inst_aok);
        check_eq("data_addr_ok", data_addr_ok, e_data_aok);
        check_eq("inst_data_ok", inst_data_ok, e_iok);
        check_eq("data_data_ok", data_data_ok, e_dok);
        check_eq("inst_rdata", inst_rdata, slv_rdata);
        check_eq("data_rdata", data_rdata, slv_rdata);
    endtask

    task automatic adv();
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (m_win_v) begin
                       m_own = m_win;
                       if (slv_addr_ok) begin m_last = m_win; m_phase = 2; end
                       else m_phase = 1;
                   end
                1: if (slv_addr_ok) begin m_last = m_own; m_phase = 2; end
                default: if (slv_data_ok) m_phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        slv_rdata = 0; slv_addr_ok = 0; slv_data_ok = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        settle();
        adv();
        resetn = 1'b1;
    endtask

    bit          pend_i, pend_d;
    int          pulses;

    initial begin
        clear_inputs();
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        settle();
        check_eq("reset_slv_req", slv_req, 1'b0);
        adv();
        resetn = 1'b1;

        // Contention right after reset: data, then inst, then data.
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h0000_2000;
        slv_addr_ok = 1;
        settle();
        check_eq("rr1_addr", slv_addr, 32'h0000_2000);
        check_eq("rr1_daok", data_addr_ok, 1'b1);
        adv();
        data_req = 0; slv_addr_ok = 0; slv_data_ok = 1;
        settle(); adv();
        data_req = 1; slv_data_ok = 0; slv_addr_ok = 1;
        settle();
        check_eq("rr2_addr", slv_addr, 32'h0000_1000);
        adv();
        inst_req = 0; data_req = 0; slv_addr_ok = 0; slv_data_ok = 1;
        settle(); adv();
        inst_req = 1; data_req = 1; slv_data_ok = 0; slv_addr_ok = 1;
        settle();
        check_eq("rr3_addr", slv_addr, 32'h0000_2000);
        adv();
        clear_inputs(); slv_data_ok = 1;
        settle(); adv();
        clear_inputs();

        // Single inst read with data_ok three cycles after addr_ok.
        inst_req = 1; inst_addr = 32'hBFC0_0000; slv_addr_ok = 1;
        settle();
        check_eq("rd_iaok", inst_addr_ok, 1'b1);
        adv();
        inst_req = 0; slv_addr_ok = 0;
        settle(); adv();
        settle(); adv();
        slv_data_ok = 1; slv_rdata = 32'h3C1D_8000;
        settle();
        check_eq("rd_idok", inst_data_ok, 1'b1);
        check_eq("rd_rdata", inst_rdata, 32'h3C1D_8000);
        check_eq("rd_ddok", data_data_ok, 1'b0);
        adv();
        clear_inputs();

        // Grant lock while addr_ok is withheld.
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) begin data_req = 1; data_addr = 32'h8000_0040; end
            settle();
            check_eq("lock_addr", slv_addr, 32'hBFC0_0100);
            adv();
        end
        slv_addr_ok = 1;
        settle();
        check_eq("lock_iaok", inst_addr_ok, 1'b1);
        adv();
        inst_req = 0; slv_addr_ok = 0; slv_data_ok = 1;
        settle();
        check_eq("lock_idok", inst_data_ok, 1'b1);
        adv();
        slv_data_ok = 0; slv_addr_ok = 1;
        settle();
        check_eq("lock_then_data", slv_addr, 32'h8000_0040);
        adv();
        clear_inputs(); slv_data_ok = 1;
        settle(); adv();
        clear_inputs();

        // Data byte write; slave holds data_ok two cycles, only one strobe.
        data_req = 1; data_wr = 1; data_size = 2'd0;
        data_addr = 32'h1FAF_0000; data_wdata = 32'h0000_00A5; slv_addr_ok = 1;
        settle();
        check_eq("wr_wr", slv_wr, 1'b1);
        check_eq("wr_size", slv_size, 2'd0);
        check_eq("wr_wdata", slv_wdata, 32'h0000_00A5);
        adv();
        clear_inputs();
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            slv_data_ok = (c == 1 || c == 2);
            settle();
            if (data_data_ok) pulses++;
            adv();
        end
        check_eq("wr_pulses", pulses, 1);
        clear_inputs();

        // Reset while waiting for data_ok; late data_ok must be ignored.
        inst_req = 1; inst_addr = 32'h0000_0300; slv_addr_ok = 1;
        settle(); adv();
        inst_req = 0; slv_addr_ok = 0;
        do_reset();
        check_eq("rst_req", slv_req, 1'b0);
        slv_data_ok = 1;
        settle();
        check_eq("rst_late_iok", inst_data_ok, 1'b0);
        adv();
        slv_data_ok = 0; data_req = 1; data_addr = 32'h0000_0400; slv_addr_ok = 1;
        settle();
        check_eq("rst_next", data_addr_ok, 1'b1);
        adv();
        clear_inputs(); slv_data_ok = 1;
        settle(); adv();
        clear_inputs();

        // Spurious data_ok in IDLE.
        slv_data_ok = 1;
        settle();
        check_eq("spur_iok", inst_data_ok, 1'b0);
        check_eq("spur_dok", data_data_ok, 1'b0);
        adv();
        clear_inputs();

        // Randomized traffic: masters hold a request until its addr_ok.
        pend_i = 0; pend_d = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend_i && $urandom_range(0, 3) == 0) begin
                pend_i = 1; inst_wr = 1'($urandom_range(0, 1));
                inst_size = 2'($urandom_range(0, 2));
                inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!pend_d && $urandom_range(0, 3) == 0) begin
                pend_d = 1; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2));
                data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req = pend_i;
            data_req = pend_d;
            slv_addr_ok = 1'($urandom_range(0, 1));
            slv_data_ok = ($urandom_range(0, 2) == 0);
            slv_rdata = $urandom;
            if (c % 700 == 699) begin
                do_reset();
                pend_i = 0; pend_d = 0;
            end else begin
                settle();
                if (e_inst_aok) pend_i = 0;
                if (e_data_aok) pend_d = 0;
                adv();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
